// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32I opcode classes and instruction field helpers
package rv_pkg;

    localparam logic [6:0] OP_REGREG = 7'b0110011;
    localparam logic [6:0] OP_REGIMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Bubble inserted on stalls and flushes: addi x0,x0,0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    function automatic logic [4:0] get_rd(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    function automatic logic [4:0] get_rs1(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] get_rs2(input logic [31:0] inst);
        return inst[24:20];
    endfunction

    function automatic logic writes_rd(input logic [31:0] inst);
        case (inst[6:0])
            OP_REGREG, OP_REGIMM, OP_LOAD, OP_JAL,
            OP_JALR, OP_LUI, OP_AUIPC:            writes_rd = 1'b1;
            default:                              writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [31:0] inst);
        case (inst[6:0])
            OP_REGREG, OP_REGIMM, OP_LOAD,
            OP_STORE, OP_BRANCH, OP_JALR:         uses_rs1 = 1'b1;
            default:                              uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [31:0] inst);
        case (inst[6:0])
            OP_REGREG, OP_STORE, OP_BRANCH:       uses_rs2 = 1'b1;
            default:                              uses_rs2 = 1'b0;
        endcase
    endfunction

    function automatic logic is_load(input logic [31:0] inst);
        return inst[6:0] == OP_LOAD;
    endfunction

    function automatic logic is_ctrl(input logic [31:0] inst);
        case (inst[6:0])
            OP_BRANCH, OP_JAL, OP_JALR:           is_ctrl = 1'b1;
            default:                              is_ctrl = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// rtl/pipe_fwd_sel.sv - youngest-producer forwarding select for one operand
module pipe_fwd_sel
    import rv_pkg::*;
#(
    parameter int PIPE_DEPTH = 3,
    parameter int SEL_W      = $clog2(PIPE_DEPTH)
) (
    input  logic [PIPE_DEPTH-1:0][31:0] i_stages,
    input  logic                        i_use,
    input  logic [4:0]                  i_rs,
    output logic [SEL_W-1:0]            o_sel
);

    logic w_active;

    assign w_active = i_use && (i_rs != 5'd0);

    // Walk oldest to youngest so the nearest producer overwrites older matches.
    always_comb begin
        o_sel = '0;
        for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
            if (w_active && writes_rd(i_stages[k]) && (get_rd(i_stages[k]) == i_rs)) begin
                o_sel = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - in-flight instruction tracker: forwarding, load-use stall, flush, writeback
module pipe_hazard_ctrl
    import rv_pkg::*;
#(
    parameter int PIPE_DEPTH   = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16,
    parameter int SEL_W        = $clog2(PIPE_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst_i,
    input  logic             inst_valid_i,
    output logic             inst_ready_o,
    input  logic             br_taken_i,
    output logic             stall_o,
    output logic             flush_o,
    output logic [SEL_W-1:0] fwd_a_sel_o,
    output logic [SEL_W-1:0] fwd_b_sel_o,
    output logic [31:0]      ex_inst_o,
    output logic             reg_w_en_o,
    output logic [4:0]       wb_rd_o,
    output logic [CNT_W-1:0] hazard_cnt_o
);

    logic [PIPE_DEPTH-1:0][31:0] r_stage;
    logic [2:0]                  r_flush_cnt;
    logic                        r_ready_en;
    logic [CNT_W-1:0]            r_hazard_cnt;

    logic [31:0] w_ex;
    logic [31:0] w_wb;
    logic [4:0]  w_ex_rd;
    logic        w_flush_trig;
    logic        w_flush;
    logic        w_load_use;
    logic        w_accept;

    assign w_ex    = r_stage[0];
    assign w_wb    = r_stage[PIPE_DEPTH-1];
    assign w_ex_rd = get_rd(w_ex);

    assign w_flush_trig = br_taken_i && is_ctrl(w_ex);
    assign w_flush      = w_flush_trig || (r_flush_cnt != 3'd0);

    assign w_load_use = is_load(w_ex) && (w_ex_rd != 5'd0) && inst_valid_i &&
                        ((uses_rs1(inst_i) && (get_rs1(inst_i) == w_ex_rd)) ||
                         (uses_rs2(inst_i) && (get_rs2(inst_i) == w_ex_rd)));

    // A flush swallows the front-end instruction, so it never needs to be held.
    assign stall_o      = w_load_use && !w_flush;
    assign flush_o      = w_flush;
    assign inst_ready_o = r_ready_en && (w_flush || !w_load_use);
    assign w_accept     = inst_valid_i && inst_ready_o && !w_flush;

    assign ex_inst_o    = w_ex;
    assign reg_w_en_o   = writes_rd(w_wb) && (get_rd(w_wb) != 5'd0);
    assign wb_rd_o      = reg_w_en_o ? get_rd(w_wb) : 5'd0;
    assign hazard_cnt_o = r_hazard_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= w_accept ? inst_i : INST_NOP;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    // Counts the remaining flush cycles after the triggering one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= 3'd0;
        end else if (w_flush_trig) begin
            r_flush_cnt <= 3'(FLUSH_CYCLES - 1);
        end else if (r_flush_cnt != 3'd0) begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hazard_cnt <= '0;
        end else if ((stall_o || w_flush) && (r_hazard_cnt != '1)) begin
            r_hazard_cnt <= r_hazard_cnt + CNT_W'(1);
        end
    end

    pipe_fwd_sel #(
        .PIPE_DEPTH (PIPE_DEPTH),
        .SEL_W      (SEL_W)
    ) u_fwd_a (
        .i_stages (r_stage),
        .i_use    (uses_rs1(w_ex)),
        .i_rs     (get_rs1(w_ex)),
        .o_sel    (fwd_a_sel_o)
    );

    pipe_fwd_sel #(
        .PIPE_DEPTH (PIPE_DEPTH),
        .SEL_W      (SEL_W)
    ) u_fwd_b (
        .i_stages (r_stage),
        .i_use    (uses_rs2(w_ex)),
        .i_rs     (get_rs2(w_ex)),
        .o_sel    (fwd_b_sel_o)
    );

endmodule
